// File: rtl/fifo_ctrl.sv
// fifo_ctrl: circular FIFO pointer and status controller driving a register file
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(1);
  logic rd_ok, wr_ok, push_only, pop_only;
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  always_comb begin
    rd_ok = rd & ~empty_q;
    wr_ok = wr & (~full_q | rd_ok);
    push_only = wr_ok & ~rd_ok;
    pop_only = rd_ok & ~wr_ok;
    w_ptr_d = wr_ok ? w_ptr_q + STEP : w_ptr_q;
    r_ptr_d = rd_ok ? r_ptr_q + STEP : r_ptr_q;
    count_d = push_only ? count_q + ONE : pop_only ? count_q - ONE : count_q;
    full_d = push_only ? (count_q == LAST) : pop_only ? 1'b0 : full_q;
    empty_d = pop_only ? (count_q == ONE) : push_only ? 1'b0 : empty_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  assign we = wr_ok;
  assign w_addr = w_ptr_q;
  assign r_addr = r_ptr_q;
  assign full = full_q;
  assign empty = empty_q;
  assign count = count_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a register-file model and queue scoreboard
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic [3:0] din = '0;
  logic we, full, empty;
  logic [2:0] w_addr, r_addr;
  logic [3:0] count;
  logic [3:0] mem [8];
  logic [3:0] data_r;
  int errors = 0;
  int checks = 0;

  fifo_ctrl #(.ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .we(we),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (we) mem[w_addr] <= din;
  assign data_r = mem[r_addr];

  typedef struct {
    logic wr, rd;
    logic [3:0] din;
    logic hv;
    logic [3:0] hd;
    logic we;
    logic [3:0] cnt;
    logic f, e;
    logic [2:0] wa, ra;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic state_chk(input logic [3:0] c, input logic f, input logic e,
                           input logic [2:0] wa, input logic [2:0] ra);
    chk("count", 32'(count), 32'(c));
    chk("full", 32'(full), 32'(f));
    chk("empty", 32'(empty), 32'(e));
    chk("w_addr", 32'(w_addr), 32'(wa));
    chk("r_addr", 32'(r_addr), 32'(ra));
  endtask

  task automatic push_cycle(input logic [3:0] d);
    wr = 1'b1; rd = 1'b0; din = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  vec_t tbl [27];
  logic [3:0] q [$];
  int tot_push, tot_pop;
  logic w, r, exp_we;
  logic [3:0] d;

  initial begin
    tbl = '{
      '{1,0,4'h1,0,4'h0,1,4'd1,0,0,3'd1,3'd0},
      '{1,0,4'h2,0,4'h0,1,4'd2,0,0,3'd2,3'd0},
      '{1,0,4'h3,0,4'h0,1,4'd3,0,0,3'd3,3'd0},
      '{1,0,4'h4,0,4'h0,1,4'd4,0,0,3'd4,3'd0},
      '{1,0,4'h5,0,4'h0,1,4'd5,0,0,3'd5,3'd0},
      '{1,0,4'h6,0,4'h0,1,4'd6,0,0,3'd6,3'd0},
      '{1,0,4'h7,0,4'h0,1,4'd7,0,0,3'd7,3'd0},
      '{1,0,4'h8,0,4'h0,1,4'd8,1,0,3'd0,3'd0},
      '{1,0,4'h9,0,4'h0,0,4'd8,1,0,3'd0,3'd0},
      '{1,1,4'hF,1,4'h1,1,4'd8,1,0,3'd1,3'd1},
      '{0,1,4'h0,1,4'h2,0,4'd7,0,0,3'd1,3'd2},
      '{0,0,4'h0,0,4'h0,0,4'd7,0,0,3'd1,3'd2},
      '{0,1,4'h0,1,4'h3,0,4'd6,0,0,3'd1,3'd3},
      '{0,1,4'h0,1,4'h4,0,4'd5,0,0,3'd1,3'd4},
      '{0,1,4'h0,1,4'h5,0,4'd4,0,0,3'd1,3'd5},
      '{0,1,4'h0,1,4'h6,0,4'd3,0,0,3'd1,3'd6},
      '{0,1,4'h0,1,4'h7,0,4'd2,0,0,3'd1,3'd7},
      '{0,1,4'h0,1,4'h8,0,4'd1,0,0,3'd1,3'd0},
      '{0,1,4'h0,1,4'hF,0,4'd0,0,1,3'd1,3'd1},
      '{0,1,4'h0,0,4'h0,0,4'd0,0,1,3'd1,3'd1},
      '{1,1,4'hA,0,4'h0,1,4'd1,0,0,3'd2,3'd1},
      '{0,1,4'h0,1,4'hA,0,4'd0,0,1,3'd2,3'd2},
      '{1,0,4'h3,0,4'h0,1,4'd1,0,0,3'd3,3'd2},
      '{1,0,4'h4,0,4'h0,1,4'd2,0,0,3'd4,3'd2},
      '{1,1,4'h5,1,4'h3,1,4'd2,0,0,3'd5,3'd3},
      '{0,1,4'h0,1,4'h4,0,4'd1,0,0,3'd5,3'd4},
      '{0,1,4'h0,1,4'h5,0,4'd0,0,1,3'd5,3'd5}
    };
    #12;
    state_chk(4'd0, 1'b0, 1'b1, 3'd0, 3'd0);
    chk("reset_we", 32'(we), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      wr = tbl[i].wr; rd = tbl[i].rd; din = tbl[i].din;
      @(negedge clk);
      chk($sformatf("we[%0d]", i), 32'(we), 32'(tbl[i].we));
      if (tbl[i].hv) chk($sformatf("head[%0d]", i), 32'(data_r), 32'(tbl[i].hd));
      @(posedge clk); #1;
      state_chk(tbl[i].cnt, tbl[i].f, tbl[i].e, tbl[i].wa, tbl[i].ra);
    end
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 5; i++) push_cycle(4'(i + 1));
    chk("pre_reset_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    state_chk(4'd0, 1'b0, 1'b1, 3'd0, 3'd0);
    chk("async_reset_we", 32'(we), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    tot_push = 0; tot_pop = 0;
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 4'($urandom);
      wr = w; rd = r; din = d;
      @(negedge clk);
      exp_we = w && (q.size() < 8 || (r && q.size() > 0));
      chk("rand_we", 32'(we), 32'(exp_we));
      if (r && q.size() > 0) chk("rand_head", 32'(data_r), 32'(q[0]));
      @(posedge clk); #1;
      if (r && q.size() > 0) begin
        void'(q.pop_front());
        tot_pop++;
      end
      if (exp_we) begin
        q.push_back(d);
        tot_push++;
      end
      state_chk(4'(q.size()), q.size() == 8, q.size() == 0, 3'(tot_push % 8), 3'(tot_pop % 8));
    end
    wr = 1'b0; rd = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
